// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and constants for the CPU memory arbiter
package mips_cpu_pkg;

    // Arbiter FSM states: idle, fetch command, data command, one-cycle response
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD_I = 2'd1,
        CMD_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Which requester owns the current (or most recent) transaction
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mips_cpu_wait_timer.sv
// rtl/mips_cpu_wait_timer.sv - waitrequest stall counter with abort threshold
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the counter (held while no command is on the bus)
//   en         : count this cycle (command active and bus stalled)
//   expired    : this stalled cycle is the WAIT_LIMIT-th of the command
module mips_cpu_wait_timer #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // The counter holds the number of stalls already seen, so the current
    // stall is the WAIT_LIMIT-th one when the count sits one below the limit.
    generate
        if (WAIT_LIMIT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = en && (count == CW'(WAIT_LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// rtl/mips_cpu_mem_arbiter.sv - round-robin arbiter of fetch and load/store onto one memory master
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   i_req/i_addr                    : fetch request (read only)
//   i_ack/i_rdata/i_err             : fetch completion pulse, data, error
//   d_req/d_we/d_addr/d_wdata/d_be  : load/store request
//   d_ack/d_rdata/d_err             : load/store completion pulse, data, error
//   m_*                             : Avalon-MM style master port
//   busy                            : arbiter is not idle
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    output logic              busy
);

    arb_state_t state, state_nxt;
    grant_t     last_grant, grant_nxt;

    logic              any_req, pick_d, mis_i, mis_d, in_cmd, expired;
    logic              rsp_fire, rsp_err, rsp_d;
    logic [31:0]       rsp_data;
    logic [ADDR_W-1:0] addr_nxt;
    logic              read_nxt, write_nxt, busy_nxt;
    logic [31:0]       wdata_nxt;
    logic [3:0]        be_nxt;

    assign any_req = i_req || d_req;
    // Data wins if it is alone, or on a tie when fetch was served last
    assign pick_d  = d_req && (!i_req || (last_grant == GNT_I));
    assign mis_i   = (i_addr[1:0] != 2'b00);
    assign mis_d   = (d_addr[1:0] != 2'b00) || (d_be == 4'h0);
    assign in_cmd  = (state == CMD_I) || (state == CMD_D);

    mips_cpu_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_cmd),
        .en     (in_cmd && m_waitrequest),
        .expired(expired)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= GNT_D;
            m_address    <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_writedata  <= '0;
            m_byteenable <= '0;
            i_ack        <= 1'b0;
            i_rdata      <= '0;
            i_err        <= 1'b0;
            d_ack        <= 1'b0;
            d_rdata      <= '0;
            d_err        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant   <= grant_nxt;
            m_address    <= addr_nxt;
            m_read       <= read_nxt;
            m_write      <= write_nxt;
            m_writedata  <= wdata_nxt;
            m_byteenable <= be_nxt;
            i_ack        <= rsp_fire && !rsp_d;
            i_rdata      <= rsp_d ? 32'h0 : rsp_data;
            i_err        <= rsp_err && !rsp_d;
            d_ack        <= rsp_fire && rsp_d;
            d_rdata      <= rsp_d ? rsp_data : 32'h0;
            d_err        <= rsp_err && rsp_d;
            busy         <= busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (pick_d) state_nxt = mis_d ? RESP : CMD_D;
                    else        state_nxt = mis_i ? RESP : CMD_I;
                end
            end
            CMD_I, CMD_D: begin
                if (!m_waitrequest || expired) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        grant_nxt = last_grant;
        addr_nxt  = m_address;
        read_nxt  = m_read;
        write_nxt = m_write;
        wdata_nxt = m_writedata;
        be_nxt    = m_byteenable;
        rsp_fire  = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = 32'h0;
        rsp_d     = (last_grant == GNT_D);
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (pick_d) begin
                        grant_nxt = GNT_D;
                        rsp_d     = 1'b1;
                        if (mis_d) begin
                            rsp_fire = 1'b1;
                            rsp_err  = 1'b1;
                        end else begin
                            addr_nxt  = {d_addr[ADDR_W-1:2], 2'b00};
                            read_nxt  = ~d_we;
                            write_nxt = d_we;
                            wdata_nxt = d_wdata;
                            be_nxt    = d_be;
                        end
                    end else begin
                        grant_nxt = GNT_I;
                        rsp_d     = 1'b0;
                        if (mis_i) begin
                            rsp_fire = 1'b1;
                            rsp_err  = 1'b1;
                        end else begin
                            addr_nxt  = {i_addr[ADDR_W-1:2], 2'b00};
                            read_nxt  = 1'b1;
                            write_nxt = 1'b0;
                            be_nxt    = BE_ALL;
                        end
                    end
                end
            end
            CMD_I, CMD_D: begin
                if (!m_waitrequest) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    rsp_fire  = 1'b1;
                    rsp_data  = m_read ? m_readdata : 32'h0;
                end else if (expired) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    rsp_fire  = 1'b1;
                    rsp_err   = 1'b1;
                end
            end
            default: ;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb/tb_mips_cpu_mem_arbiter.sv - scoreboard bench for the CPU memory arbiter
module tb_mips_cpu_mem_arbiter;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    mips_cpu_mem_arbiter #(
        .WAIT_LIMIT(WL),
        .ADDR_W    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .i_err        (i_err),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_be         (d_be),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_byteenable (m_byteenable),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       exp_i[$];
    resp_t       exp_d[$];
    int          ack_order[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem[int];
    logic [31:0] dev_mem[int];
    int          stall_cfg = 0;
    bit          stuck = 1'b0;
    int          last_cmd_cycles = 0;
    bit          last_cmd_read = 1'b0;
    int          cmd_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        return 32'(w) * 32'h9E3779B1 ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w = int'(a >> 2);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        int w = int'(a >> 2);
        return dev_mem.exists(w) ? dev_mem[w] : init_word(w);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] v;
        v = model_read(a);
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        ref_mem[int'(a >> 2)] = v;
    endtask

    task automatic push_i(input logic [31:0] rd, input logic er);
        resp_t e;
        e.rdata = rd;
        e.err   = er;
        exp_i.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] rd, input logic er);
        resp_t e;
        e.rdata = rd;
        e.err   = er;
        exp_d.push_back(e);
    endtask

    // lat = number of cycles from the sampling edge to the ack cycle (inclusive)
    task automatic do_fetch(input logic [31:0] a, input bit tmo, output int lat);
        @(negedge clk);
        if (a[1:0] != 2'b00 || tmo) push_i(32'h0, 1'b1);
        else                        push_i(model_read(a), 1'b0);
        i_addr = a;
        i_req  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!i_ack && lat < 100);
        if (!i_ack) begin
            tests++;
            fails++;
            $display("FAIL fetch_ack_wait: i_ack=0 after %0d cycles, required 1", lat);
        end
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [3:0] be, input bit tmo, output int lat);
        @(negedge clk);
        if (a[1:0] != 2'b00 || be == 4'h0 || tmo) begin
            push_d(32'h0, 1'b1);
        end else if (we) begin
            model_write(a, wd, be);
            push_d(32'h0, 1'b0);
        end else begin
            push_d(model_read(a), 1'b0);
        end
        d_addr  = a;
        d_we    = we;
        d_wdata = wd;
        d_be    = be;
        d_req   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_ack && lat < 100);
        if (!d_ack) begin
            tests++;
            fails++;
            $display("FAIL data_ack_wait: d_ack=0 after %0d cycles, required 1", lat);
        end
        d_req = 1'b0;
    endtask

    // Monitor: pops the expected response whenever an ack is presented
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (i_ack && d_ack) begin
                tests++;
                fails++;
                $display("FAIL ack_overlap: i_ack=1 d_ack=1, required at most one");
            end
            if (i_ack) begin
                ack_order.push_back(0);
                if (exp_i.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL i_ack_unexpected: i_ack=1, required 0");
                end else begin
                    e = exp_i.pop_front();
                    check("i_rdata", i_rdata, e.rdata);
                    check("i_err", 32'(i_err), 32'(e.err));
                end
            end
            if (d_ack) begin
                ack_order.push_back(1);
                if (exp_d.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL d_ack_unexpected: d_ack=1, required 0");
                end else begin
                    e = exp_d.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                    check("d_err", 32'(d_err), 32'(e.err));
                end
            end
        end
    end

    // Bus slave: stall generation, memory, command stability
    initial begin : slave
        int          stall_left;
        int          cycles;
        bit          in_cmd;
        bit          stable;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;
        logic        rd0, wr0;
        stall_left = 0;
        cycles = 0;
        in_cmd = 1'b0;
        stable = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (m_read || m_write) begin
                if (!in_cmd) begin
                    in_cmd = 1'b1;
                    cmd_count++;
                    cycles = 0;
                    stable = 1'b1;
                    a0 = m_address; wd0 = m_writedata; be0 = m_byteenable;
                    rd0 = m_read; wr0 = m_write;
                    stall_left = stuck ? (1 << 20) :
                                 (stall_cfg < 0 ? int'($urandom_range(0, 3)) : stall_cfg);
                    check("bus_align", 32'(m_address[1:0]), 32'h0);
                    check("bus_one_strobe", 32'(m_read & m_write), 32'h0);
                end else if (m_address !== a0 || m_read !== rd0 || m_write !== wr0 ||
                             m_byteenable !== be0 || (wr0 && m_writedata !== wd0)) begin
                    stable = 1'b0;
                end
                cycles++;
                if (stall_left > 0) begin
                    m_waitrequest = 1'b1;
                    stall_left--;
                    m_readdata = $urandom;
                end else begin
                    m_waitrequest = 1'b0;
                    if (m_read) begin
                        m_readdata = dev_read(m_address);
                    end else begin
                        logic [31:0] v;
                        v = dev_read(m_address);
                        for (int b = 0; b < 4; b++)
                            if (m_byteenable[b]) v[8*b +: 8] = m_writedata[8*b +: 8];
                        dev_mem[int'(m_address >> 2)] = v;
                        m_readdata = $urandom;
                    end
                end
            end else begin
                if (in_cmd) begin
                    check("bus_stable", 32'(stable), 32'h1);
                    last_cmd_cycles = cycles;
                    last_cmd_read = rd0;
                    if (stuck && !reset) check("timeout_strobe_cycles", cycles, WL);
                end
                in_cmd = 1'b0;
                m_waitrequest = stuck;
                m_readdata = $urandom;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: run did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat, c0;
        ref_mem[4] = 32'hDEADBEEF;
        dev_mem[4] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check("rst_m_read", 32'(m_read), 0);
        check("rst_m_write", 32'(m_write), 0);
        check("rst_i_ack", 32'(i_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_m_address", m_address, 0);
        reset = 1'b0;

        // 1: fetch, no wait states, exact cycle timing
        stall_cfg = 0;
        @(negedge clk);
        push_i(32'hDEADBEEF, 1'b0);
        i_addr = 32'h10;
        i_req = 1'b1;
        @(negedge clk);
        check("t1_m_read", 32'(m_read), 1);
        check("t1_m_address", m_address, 32'h10);
        check("t1_m_byteenable", 32'(m_byteenable), 32'hF);
        check("t1_i_ack_early", 32'(i_ack), 0);
        check("t1_busy", 32'(busy), 1);
        @(negedge clk);
        check("t1_i_ack", 32'(i_ack), 1);
        check("t1_d_ack", 32'(d_ack), 0);
        check("t1_m_read_drop", 32'(m_read), 0);
        i_req = 1'b0;
        @(negedge clk);
        check("t1_i_ack_pulse", 32'(i_ack), 0);
        check("t1_busy_idle", 32'(busy), 0);

        // 2: data write with 3 wait states, then read it back
        stall_cfg = 3;
        do_data(32'h100, 1'b1, 32'h12345678, 4'b0011, 1'b0, lat);
        check("t2_write_latency", lat, 5);
        check("t2_write_cycles", last_cmd_cycles, 4);
        check("t2_not_read", 32'(last_cmd_read), 0);
        stall_cfg = 0;
        do_data(32'h100, 1'b0, 32'h0, 4'hF, 1'b0, lat);
        check("t2_read_latency", lat, 2);

        // 4: misaligned accesses never reach the bus
        c0 = cmd_count;
        do_fetch(32'h2, 1'b0, lat);
        check("t4_fetch_latency", lat, 1);
        do_data(32'h2004, 1'b0, 32'h0, 4'h0, 1'b0, lat);
        check("t4_data_latency", lat, 1);
        check("t4_no_bus_cycle", cmd_count, c0);

        // 5: timeout, then a normal access
        stuck = 1'b1;
        do_fetch(32'h20, 1'b1, lat);
        check("t5_timeout_latency", lat, WL + 1);
        stuck = 1'b0;
        do_fetch(32'h24, 1'b0, lat);
        check("t5_recover_latency", lat, 2);

        // 6: reset in the middle of a stalled write
        stuck = 1'b1;
        @(negedge clk);
        d_addr = 32'h2008; d_we = 1'b1; d_wdata = 32'hA5A5A5A5; d_be = 4'hF;
        d_req = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_m_write_before", 32'(m_write), 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_m_write", 32'(m_write), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_d_ack", 32'(d_ack), 0);
        d_req = 1'b0;
        reset = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check("t6_d_ack_after", 32'(d_ack), 0);

        // 3: simultaneous requests after reset alternate starting with fetch
        ack_order.delete();
        fork
            begin
                int la;
                do_fetch(32'h30, 1'b0, la);
                do_fetch(32'h34, 1'b0, la);
            end
            begin
                int lb;
                do_data(32'h2010, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, lb);
                do_data(32'h2010, 1'b0, 32'h0, 4'hF, 1'b0, lb);
            end
        join
        check("t3_ack_count", ack_order.size(), 4);
        for (int k = 0; k < ack_order.size() && k < 4; k++)
            check("t3_order", ack_order[k], k % 2);

        // Random traffic from both requesters concurrently
        stall_cfg = -1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int la;
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = {20'h0, 12'($urandom_range(0, 4095))};
                    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                    do_fetch(a, 1'b0, la);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    int lb;
                    logic [31:0] a;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = 32'h2000 + 32'(4 * $urandom_range(0, 15));
                    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    do_data(a, 1'($urandom_range(0, 1)), $urandom,
                            4'($urandom_range(0, 15)), 1'b0, lb);
                end
            end
        join

        repeat (5) @(negedge clk);
        check("exp_i_drained", exp_i.size(), 0);
        check("exp_d_drained", exp_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
Name: mips_cpu_mem_arbiter

Overview:
Shares the CPU's single Avalon-MM style memory master port between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read/write with byte enables). Each requester uses a simple req/ack handshake. The arbiter drives the bus, absorbs waitrequest stalls and returns read data. It also reports misaligned accesses and bus timeouts as errors. It sits between the CPU sequencing FSM/datapath and the top-level memory interface.

Parameters:
WAIT_LIMIT, 255, max consecutive cycles waitrequest may be held on one transaction before abort; 0 disables the timeout.
ADDR_W, 32, address width in bits.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
i_req  in  1  fetch request; held high until i_ack
i_addr  in  ADDR_W  fetch byte address
i_ack  out  1  one-cycle pulse: fetch complete
i_rdata  out  32  fetch data, valid while i_ack=1
i_err  out  1  valid with i_ack: misaligned or timeout
d_req  in  1  data request; held high until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  write data
d_be  in  4  byte enables
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  32  read data, valid while d_ack=1
d_err  out  1  valid with d_ack
m_address  out  ADDR_W  bus address (word aligned, [1:0]=0)
m_read  out  1  bus read strobe
m_write  out  1  bus write strobe
m_writedata  out  32  bus write data
m_byteenable  out  4  bus byte enables
m_readdata  in  32  bus read data, valid when m_read=1 and m_waitrequest=0
m_waitrequest  in  1  bus stall
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. At the edge with reset=1: state=IDLE; all outputs 0; wait counter 0; last_grant=DATA. Reset mid-transaction aborts it with no ack; m_read/m_write are 0 from the following cycle.
- All outputs are registered.
- States: IDLE, CMD_I, CMD_D, RESP.
- IDLE arbitration:
  - One request only: grant it.
  - Both requests: round-robin; grant the requester that is not last_grant. After reset, the first tie grants fetch.
  - Update last_grant on every grant.
- Alignment check at grant:
  - Fetch: i_addr[1:0]!=0 is misaligned.
  - Data: misaligned if d_addr[1:0]!=0, or d_be==0.
  - A misaligned request goes straight to RESP with err=1 and rdata=0. No bus cycle is issued.
- Aligned grant: next state CMD_I or CMD_D. The bus fields are latched from the requester at grant and held stable throughout the command.
  - CMD_I: m_read=1, m_byteenable=4'hF.
  - CMD_D: m_read=~d_we, m_write=d_we, m_writedata=d_wdata, m_byteenable=d_be.
- CMD_x cycles:
  - m_waitrequest=1: remain in CMD_x and increment the wait counter.
  - m_waitrequest=0: capture m_readdata (reads only; writes return 0), drop strobes, go to RESP, err=0.
  - Timeout: if WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT while waitrequest=1, drop strobes and go to RESP with err=1, rdata=0.
  - The counter clears on entry to every CMD_x.
- RESP: exactly one cycle. The granted requester's ack=1, plus rdata and err. Requests are ignored in this cycle. Next state is IDLE.
  - The requester must deassert req in its ack cycle. A req still high in the following IDLE is a new request.
- Minimum latency, zero wait states: req sampled in IDLE at edge N, strobe high for cycle N+1, ack high for cycle N+2. This gives 3 cycles per transaction.
- A request arriving during another requester's transaction waits. Round-robin bounds its wait to one transaction.
- Inputs are not required to change during CMD; changes there are ignored because the bus fields are latched.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - arb_state_t enum {IDLE, CMD_I, CMD_D, RESP}
  - grant_t {GNT_I, GNT_D}
  - constant BE_ALL=4'hF
- Natural sub-module: mips_cpu_wait_timer. It is the wait counter, parameterised by WAIT_LIMIT, with inputs clear/en and output expired.
- The FSM and datapath registers remain in the top module.

Test Plan:
1. Fetch, no wait: i_req=1, i_addr=0x0000_0010, m_readdata=0xDEADBEEF, waitrequest=0 -> m_read=1 for cycle 2 with m_address=0x10; i_ack=1, i_rdata=0xDEADBEEF, i_err=0 in cycle 3; d_ack stays 0.
2. Data write with 3 wait states: d_we=1, d_addr=0x100, d_wdata=0x12345678, d_be=4'b0011 -> m_write held 4 cycles with stable fields; d_ack one cycle after waitrequest falls; m_read never asserted.
3. Simultaneous requests after reset, both held through each ack -> order is fetch, data, fetch, data. A single ack per transaction; acks never overlap.
4. Misaligned: i_addr=0x0000_0002 -> no m_read; i_ack with i_err=1, i_rdata=0 at cycle 2. Also d_be=0 -> d_err=1.
5. Timeout with WAIT_LIMIT=4 and m_waitrequest stuck 1 -> strobe dropped after 4 stalled cycles; ack with err=1. A following request with waitrequest=0 completes normally with err=0.
6. Reset asserted while in CMD_D with waitrequest=1 -> m_write=0, busy=0, no d_ack. The next tie after reset is granted to fetch.
